// File: rtl/rect_fill_fsm_if.sv
// Pixel plot port between the rectangle fill controller and the VGA adapter.
// Handshake: vga_plot is valid, plot_ready is ready; a pixel transfers on a cycle
// where both are high. While valid && !ready, the master holds x/y/colour stable.
// An abort may drop valid without a transfer.
interface rect_fill_fsm_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int C_W = 3
);
  logic [X_W-1:0] vga_x;
  logic [Y_W-1:0] vga_y;
  logic [C_W-1:0] vga_colour;
  logic           vga_plot;
  logic           plot_ready;

  modport master (
    output vga_x,
    output vga_y,
    output vga_colour,
    output vga_plot,
    input  plot_ready
  );

  modport slave (
    input  vga_x,
    input  vga_y,
    input  vga_colour,
    input  vga_plot,
    output plot_ready
  );
endinterface

// File: rtl/rect_fill_fsm.sv
// Fills a runtime rectangle, clipped to the screen, in row- or column-major order.
// Optional RECT_FILL_CHECKER_EN: adds colour_alt and a checkerboard colour pattern.
module rect_fill_fsm #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [X_W-1:0]       x0,
  input  logic [Y_W-1:0]       y0,
  input  logic [X_W-1:0]       x1,
  input  logic [Y_W-1:0]       y1,
  input  logic [C_W-1:0]       colour,
`ifdef RECT_FILL_CHECKER_EN
  input  logic [C_W-1:0]       colour_alt,
`endif
  input  logic                 col_major,
  output logic                 busy,
  output logic                 done,
  output logic [X_W+Y_W-1:0]   pix_count,
  output logic [1:0]           state_dbg,
  rect_fill_fsm_if.master      plot
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [X_W-1:0]     X_MAX  = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0]     Y_MAX  = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0]     X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0]     Y_ONE  = Y_W'(1);
  localparam logic [X_W+Y_W-1:0] PC_ONE = (X_W+Y_W)'(1);

  state_t state, state_n;

  logic [X_W-1:0] cx, x0_q, xe_q;
  logic [Y_W-1:0] cy, y0_q, ye_q;
  logic [C_W-1:0] colour_q;
  logic           col_major_q;
`ifdef RECT_FILL_CHECKER_EN
  logic [C_W-1:0] colour_alt_q;
`endif

  logic [X_W-1:0] xe_in;
  logic [Y_W-1:0] ye_in;
  logic           empty;
  logic           accept;
  logic           last;

  // Clip the far corner to the screen; the near corner is left raw so an
  // off-screen origin shows up as an empty rectangle.
  assign xe_in  = (x1 > X_MAX) ? X_MAX : x1;
  assign ye_in  = (y1 > Y_MAX) ? Y_MAX : y1;
  assign empty  = (x0 > xe_in) || (y0 > ye_in);

  assign accept = (state == DRAW) && !abort && plot.plot_ready;
  assign last   = (cx == xe_q) && (cy == ye_q);

  assign busy      = (state == DRAW);
  assign done      = (state == DONE);
  assign state_dbg = state;

  assign plot.vga_plot = (state == DRAW) && !abort;
  assign plot.vga_x    = cx;
  assign plot.vga_y    = cy;
`ifdef RECT_FILL_CHECKER_EN
  assign plot.vga_colour = (cx[0] ^ cy[0]) ? colour_alt_q : colour_q;
`else
  assign plot.vga_colour = colour_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = empty ? DONE : DRAW;
      DRAW: if (abort || (accept && last)) state_n = DONE;
      DONE: if (!start) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx           <= '0;
      cy           <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      xe_q         <= '0;
      ye_q         <= '0;
      colour_q     <= '0;
      col_major_q  <= 1'b0;
      pix_count    <= '0;
`ifdef RECT_FILL_CHECKER_EN
      colour_alt_q <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            x0_q         <= x0;
            y0_q         <= y0;
            xe_q         <= xe_in;
            ye_q         <= ye_in;
            colour_q     <= colour;
            col_major_q  <= col_major;
            cx           <= x0;
            cy           <= y0;
            pix_count    <= '0;
`ifdef RECT_FILL_CHECKER_EN
            colour_alt_q <= colour_alt;
`endif
          end
        end
        DRAW: begin
          if (accept) begin
            pix_count <= pix_count + PC_ONE;
            // Coordinates freeze on the final pixel so they never pass xe/ye.
            if (!last) begin
              if (col_major_q) begin
                if (cy == ye_q) begin
                  cy <= y0_q;
                  cx <= cx + X_ONE;
                end else begin
                  cy <= cy + Y_ONE;
                end
              end else begin
                if (cx == xe_q) begin
                  cx <= x0_q;
                  cy <= cy + Y_ONE;
                end else begin
                  cx <= cx + X_ONE;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_fill_fsm.sv
// Directed bench for rect_fill_fsm: scan orders, clipping, empty fills,
// backpressure, abort, async reset and (when enabled) the checker colouring.
module tb_rect_fill_fsm;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 3;
  localparam int MAX_CYCLES = 25000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic col_major = 1'b0;
  logic [X_W-1:0] x0 = '0, x1 = '0;
  logic [Y_W-1:0] y0 = '0, y1 = '0;
  logic [C_W-1:0] colour = '0;
`ifdef RECT_FILL_CHECKER_EN
  logic [C_W-1:0] colour_alt = '0;
`endif
  logic busy, done;
  logic [X_W+Y_W-1:0] pix_count;
  logic [1:0] state_dbg;

  rect_fill_fsm_if #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W)) plot_if ();

  rect_fill_fsm #(
    .SCREEN_W(160), .SCREEN_H(120), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .x0(x0),
    .y0(y0),
    .x1(x1),
    .y1(y1),
    .colour(colour),
`ifdef RECT_FILL_CHECKER_EN
    .colour_alt(colour_alt),
`endif
    .col_major(col_major),
    .busy(busy),
    .done(done),
    .pix_count(pix_count),
    .state_dbg(state_dbg),
    .plot(plot_if)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [X_W-1:0] acc_x_q[$];
  logic [Y_W-1:0] acc_y_q[$];
  logic [C_W-1:0] acc_c_q[$];
  logic [X_W-1:0] raw_x_q[$];
  logic [Y_W-1:0] raw_y_q[$];
  logic [X_W-1:0] exp_x_q[$];
  logic [Y_W-1:0] exp_y_q[$];
  logic [C_W-1:0] exp_q[$];
  logic abort_cycle_plot;

  function automatic logic [C_W-1:0] exp_col(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                             input logic [C_W-1:0] c, input logic [C_W-1:0] alt);
`ifdef RECT_FILL_CHECKER_EN
    return (x[0] ^ y[0]) ? alt : c;
`else
    return c;
`endif
  endfunction

  // Reference scan order over an already-clipped rectangle.
  task automatic build_expected(input int ax0, input int ay0, input int axe, input int aye,
                                input bit acm, input logic [C_W-1:0] c, input logic [C_W-1:0] alt);
    exp_x_q.delete(); exp_y_q.delete(); exp_q.delete();
    if (acm) begin
      for (int x = ax0; x <= axe; x++)
        for (int y = ay0; y <= aye; y++) begin
          exp_x_q.push_back(X_W'(x)); exp_y_q.push_back(Y_W'(y));
          exp_q.push_back(exp_col(X_W'(x), Y_W'(y), c, alt));
        end
    end else begin
      for (int y = ay0; y <= aye; y++)
        for (int x = ax0; x <= axe; x++) begin
          exp_x_q.push_back(X_W'(x)); exp_y_q.push_back(Y_W'(y));
          exp_q.push_back(exp_col(X_W'(x), Y_W'(y), c, alt));
        end
    end
  endtask

  // Starts a fill, scrambles the command inputs after the latch, and records
  // every presented and every accepted pixel until done (bounded).
  task automatic drive_fill(input int ax0, input int ay0, input int ax1, input int ay1,
                            input logic [C_W-1:0] acol, input logic [C_W-1:0] aalt,
                            input bit acm, input int ready_mode, input int abort_after,
                            output int cycles, output bit timed_out);
    x0 = X_W'(ax0); y0 = Y_W'(ay0); x1 = X_W'(ax1); y1 = Y_W'(ay1);
    colour = acol; col_major = acm;
`ifdef RECT_FILL_CHECKER_EN
    colour_alt = aalt;
`endif
    start = 1'b1; abort = 1'b0; plot_if.plot_ready = 1'b1;
    acc_x_q.delete(); acc_y_q.delete(); acc_c_q.delete();
    raw_x_q.delete(); raw_y_q.delete();
    abort_cycle_plot = 1'b0;
    @(posedge clk); #1;
    x0 = X_W'($urandom_range(0, 255)); x1 = X_W'($urandom_range(0, 255));
    y0 = Y_W'($urandom_range(0, 127)); y1 = Y_W'($urandom_range(0, 127));
    colour = C_W'($urandom_range(0, 7)); col_major = 1'($urandom_range(0, 1));
`ifdef RECT_FILL_CHECKER_EN
    colour_alt = C_W'($urandom_range(0, 7));
`endif
    cycles = 0; timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (cycles >= MAX_CYCLES) begin
        timed_out = 1'b1;
        break;
      end
      plot_if.plot_ready = (ready_mode == 1) ? (cycles % 3 == 0) : 1'b1;
      abort = (abort_after >= 0) && (acc_x_q.size() == abort_after);
      #1;
      if (abort) abort_cycle_plot = plot_if.vga_plot;
      if (plot_if.vga_plot === 1'b1) begin
        raw_x_q.push_back(plot_if.vga_x); raw_y_q.push_back(plot_if.vga_y);
        if (plot_if.plot_ready) begin
          acc_x_q.push_back(plot_if.vga_x); acc_y_q.push_back(plot_if.vga_y);
          acc_c_q.push_back(plot_if.vga_colour);
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    abort = 1'b0; plot_if.plot_ready = 1'b1;
  endtask

  task automatic end_fill();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if ({busy, done, plot_if.vga_plot, pix_count, state_dbg} !== '0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b done=%b plot=%b pix=%0d state=%0d, required all 0",
               busy, done, plot_if.vga_plot, pix_count, state_dbg);
    end
    tests_run++;
    if ({plot_if.vga_x, plot_if.vga_y, plot_if.vga_colour} !== '0) begin
      tests_failed++;
      $display("FAIL reset_pix: x=%0d y=%0d c=%0d, required 0 0 0",
               plot_if.vga_x, plot_if.vga_y, plot_if.vga_colour);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_screen();
    int cyc, errs;
    bit to;
    build_expected(0, 0, 159, 119, 1'b1, 3'd5, 3'd2);
    drive_fill(0, 0, 159, 119, 3'd5, 3'd2, 1'b1, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 19200) begin
      tests_failed++;
      $display("FAIL fs_cycles: timeout=%0d draw_cycles=%0d, required 0 19200", to, cyc);
    end
    tests_run++;
    if (acc_x_q.size() != 19200) begin
      tests_failed++;
      $display("FAIL fs_plots: got %0d plots, required 19200", acc_x_q.size());
    end else begin
      tests_run++;
      if (acc_x_q[0] !== 0 || acc_y_q[0] !== 0 || acc_x_q[1] !== 0 || acc_y_q[1] !== 1) begin
        tests_failed++;
        $display("FAIL fs_first: (%0d,%0d) (%0d,%0d), required (0,0) (0,1)",
                 acc_x_q[0], acc_y_q[0], acc_x_q[1], acc_y_q[1]);
      end
      tests_run++;
      if (acc_x_q[19199] !== 159 || acc_y_q[19199] !== 119) begin
        tests_failed++;
        $display("FAIL fs_last: (%0d,%0d), required (159,119)", acc_x_q[19199], acc_y_q[19199]);
      end
      errs = 0;
      for (int i = 0; i < 19200; i++)
        if (acc_x_q[i] !== exp_x_q[i] || acc_y_q[i] !== exp_y_q[i] || acc_c_q[i] !== exp_q[i]) errs++;
      tests_run++;
      if (errs != 0) begin
        tests_failed++;
        $display("FAIL fs_sequence: %0d pixels differ, required 0", errs);
      end
    end
    tests_run++;
    if (pix_count !== 15'd19200 || done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL fs_done: pix=%0d done=%b busy=%b, required 19200 1 0", pix_count, done, busy);
    end
    end_fill();
  endtask

  task automatic test_row_clip();
    int cyc, errs;
    bit to;
    build_expected(150, 115, 159, 119, 1'b0, 3'd3, 3'd3);
    drive_fill(150, 115, 200, 127, 3'd3, 3'd3, 1'b0, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 50 || acc_x_q.size() != 50 || pix_count !== 15'd50) begin
      tests_failed++;
      $display("FAIL clip_count: timeout=%0d cycles=%0d plots=%0d pix=%0d, required 0 50 50 50",
               to, cyc, acc_x_q.size(), pix_count);
    end else begin
      errs = 0;
      for (int i = 0; i < 50; i++)
        if (acc_x_q[i] !== exp_x_q[i] || acc_y_q[i] !== exp_y_q[i] || acc_c_q[i] !== exp_q[i]) errs++;
      tests_run++;
      if (errs != 0 || acc_x_q[1] !== 151 || acc_y_q[1] !== 115 ||
          acc_x_q[49] !== 159 || acc_y_q[49] !== 119) begin
        tests_failed++;
        $display("FAIL clip_sequence: %0d differ, second (%0d,%0d) last (%0d,%0d), required 0 (151,115) (159,119)",
                 errs, acc_x_q[1], acc_y_q[1], acc_x_q[49], acc_y_q[49]);
      end
    end
    end_fill();
  endtask

  task automatic test_empty();
    int cyc;
    bit to;
    drive_fill(10, 0, 5, 3, 3'd1, 3'd1, 1'b0, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 0 || raw_x_q.size() != 0 || pix_count !== '0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_inverted: cycles=%0d plots=%0d pix=%0d done=%b, required 0 0 0 1",
               cyc, raw_x_q.size(), pix_count, done);
    end
    // Start held high: stays in DONE with no re-trigger.
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done !== 1'b1 || plot_if.vga_plot !== 1'b0 || state_dbg !== 2'd2) begin
      tests_failed++;
      $display("FAIL done_hold: done=%b plot=%b state=%0d, required 1 0 2", done, plot_if.vga_plot, state_dbg);
    end
    end_fill();
    drive_fill(170, 0, 200, 3, 3'd1, 3'd1, 1'b0, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 0 || raw_x_q.size() != 0 || pix_count !== '0 || done !== 1'b1) begin
      tests_failed++;
      $display("FAIL empty_offscreen: cycles=%0d plots=%0d pix=%0d done=%b, required 0 0 0 1",
               cyc, raw_x_q.size(), pix_count, done);
    end
    end_fill();
  endtask

  task automatic test_backpressure();
    int cyc, errs;
    bit to;
    logic [X_W-1:0] hx[4];
    logic [Y_W-1:0] hy[4];
    hx = '{8'd3, 8'd3, 8'd4, 8'd4};
    hy = '{7'd4, 7'd5, 7'd4, 7'd5};
    drive_fill(3, 4, 4, 5, 3'd2, 3'd2, 1'b1, 1, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 10 || raw_x_q.size() != 10 || pix_count !== 15'd4) begin
      tests_failed++;
      $display("FAIL bp_count: timeout=%0d cycles=%0d presented=%0d pix=%0d, required 0 10 10 4",
               to, cyc, raw_x_q.size(), pix_count);
    end else begin
      tests_run++;
      if (raw_x_q[2] !== 3 || raw_y_q[2] !== 5 || raw_x_q[3] !== 3 || raw_y_q[3] !== 5) begin
        tests_failed++;
        $display("FAIL bp_hold: (%0d,%0d) (%0d,%0d), required (3,5) (3,5)",
                 raw_x_q[2], raw_y_q[2], raw_x_q[3], raw_y_q[3]);
      end
    end
    errs = (acc_x_q.size() == 4) ? 0 : 1;
    for (int i = 0; i < 4 && i < acc_x_q.size(); i++)
      if (acc_x_q[i] !== hx[i] || acc_y_q[i] !== hy[i]) errs++;
    tests_run++;
    if (errs != 0) begin
      tests_failed++;
      $display("FAIL bp_sequence: %0d errors over %0d accepted, required 0 over 4", errs, acc_x_q.size());
    end
    end_fill();
  endtask

  task automatic test_abort_restart();
    int cyc;
    bit to;
    drive_fill(20, 30, 23, 33, 3'd4, 3'd4, 1'b0, 0, 3, cyc, to);
    tests_run++;
    if (to !== 1'b0 || cyc !== 4 || acc_x_q.size() != 3 || pix_count !== 15'd3 || abort_cycle_plot !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: cycles=%0d accepted=%0d pix=%0d abort_plot=%b, required 4 3 3 0",
               cyc, acc_x_q.size(), pix_count, abort_cycle_plot);
    end else begin
      tests_run++;
      if (acc_x_q[2] !== 22 || acc_y_q[2] !== 30) begin
        tests_failed++;
        $display("FAIL abort_seq: third (%0d,%0d), required (22,30)", acc_x_q[2], acc_y_q[2]);
      end
    end
    end_fill();
    tests_run++;
    if (done !== 1'b0 || state_dbg !== 2'd0 || pix_count !== 15'd3) begin
      tests_failed++;
      $display("FAIL abort_idle: done=%b state=%0d pix=%0d, required 0 0 3", done, state_dbg, pix_count);
    end
    drive_fill(7, 8, 8, 8, 3'd6, 3'd6, 1'b0, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || acc_x_q.size() != 2 || pix_count !== 15'd2) begin
      tests_failed++;
      $display("FAIL restart_count: timeout=%0d plots=%0d pix=%0d, required 0 2 2", to, acc_x_q.size(), pix_count);
    end else begin
      tests_run++;
      if (acc_x_q[0] !== 7 || acc_y_q[0] !== 8 || acc_x_q[1] !== 8 || acc_y_q[1] !== 8) begin
        tests_failed++;
        $display("FAIL restart_seq: (%0d,%0d) (%0d,%0d), required (7,8) (8,8)",
                 acc_x_q[0], acc_y_q[0], acc_x_q[1], acc_y_q[1]);
      end
    end
    end_fill();
  endtask

  task automatic test_async_reset();
    x0 = 8'd1; y0 = 7'd1; x1 = 8'd4; y1 = 7'd4; colour = 3'd7; col_major = 1'b0;
    start = 1'b1; plot_if.plot_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1 || plot_if.vga_plot !== 1'b1 || pix_count !== 15'd2) begin
      tests_failed++;
      $display("FAIL arst_pre: busy=%b plot=%b pix=%0d, required 1 1 2", busy, plot_if.vga_plot, pix_count);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({busy, done, plot_if.vga_plot, plot_if.vga_x, plot_if.vga_y, plot_if.vga_colour, pix_count} !== '0) begin
      tests_failed++;
      $display("FAIL arst_now: busy=%b plot=%b x=%0d y=%0d c=%0d pix=%0d, required all 0",
               busy, plot_if.vga_plot, plot_if.vga_x, plot_if.vga_y, plot_if.vga_colour, pix_count);
    end
    start = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (plot_if.vga_plot !== 1'b0 || state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL arst_after: plot=%b state=%0d, required 0 0", plot_if.vga_plot, state_dbg);
    end
  endtask

`ifdef RECT_FILL_CHECKER_EN
  task automatic test_checker();
    int cyc;
    bit to;
    logic [C_W-1:0] hc[4];
    hc = '{3'd1, 3'd6, 3'd6, 3'd1};
    drive_fill(0, 0, 1, 1, 3'd1, 3'd6, 1'b0, 0, -1, cyc, to);
    tests_run++;
    if (to !== 1'b0 || acc_c_q.size() != 4 ||
        acc_c_q[0] !== hc[0] || acc_c_q[1] !== hc[1] || acc_c_q[2] !== hc[2] || acc_c_q[3] !== hc[3]) begin
      tests_failed++;
      $display("FAIL checker_colours: %0d plots, first colours %p, required 1 6 6 1", acc_c_q.size(), acc_c_q);
    end
    end_fill();
  endtask
`endif

  initial begin
    plot_if.plot_ready = 1'b1;
    test_reset();
    test_full_screen();
    test_row_clip();
    test_empty();
    test_backpressure();
    test_abort_restart();
    test_async_reset();
`ifdef RECT_FILL_CHECKER_EN
    test_checker();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
